cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
- Single-clock sequencer that programs the serial configuration chain of a PE block or PE array from a word-wide bitstream stream.
- The chain is the daisy-chained config cells of the ALU, MEM and switch instances.
- Sequence: pulse the chain reset, shift exactly CHAIN_LEN bits in, then optionally re-shift the same bitstream and compare the chain's serial output to prove the load.
- Sits between the host or DMA stream and the fabric. The top level gates clk with cfg_shift_en through an ICG to form config_clk.

Parameters:
- CHAIN_LEN, 256, total config bits in the chain (>=1)
- WORD_W, 32, stream word width (>=1)
- RST_CYCLES, 4, cycles config_reset is held high (>=1)
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- verify_en  in  1  sampled with start; 1 = run the VERIFY pass after LOAD
- abort  in  1  return to IDLE from any state
- s_data  in  WORD_W  bitstream word; LSB shifted first
- s_valid  in  1  s_data valid
- s_ready  out  1  word accepted when s_valid && s_ready
- cfg_sdo  out  1  serial data to the chain's config_in
- cfg_shift_en  out  1  one-cycle shift strobe (clock enable for config_clk)
- config_reset  out  1  chain reset
- config_out  in  1  serial output from the chain tail
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  sticky; cleared by the next accepted start
- error  out  1  sticky verify mismatch; cleared by the next accepted start
- err_bit_idx  out  CNT_W  index of the first mismatching bit

Behaviour:
- Reset, and abort: state=IDLE; s_ready, cfg_sdo, cfg_shift_en, config_reset, busy, done, error = 0; err_bit_idx = 0.
- After abort the chain contents are undefined and done stays 0.
- States:
  - IDLE -> RST on start.
  - RST: config_reset=1 for exactly RST_CYCLES cycles -> LOAD.
  - LOAD: shift CHAIN_LEN bits -> VERIFY if verify_en was latched, else DONE.
  - VERIFY: shift CHAIN_LEN bits and compare -> DONE.
  - DONE: idle, with done=1; start -> RST.
- start while busy is ignored.
- Abort takes priority over every other event in the same cycle.
- Buffering:
  - One WORD_W shift register plus a bits-left counter.
  - s_ready=1 in LOAD/VERIFY when bits-left==0, or when bits-left==1 and a shift happens this cycle, provided pass bits are still owed.
  - Back-to-back words give 1 bit/cycle with no bubble.
- Shift:
  - In LOAD/VERIFY, cfg_shift_en=1 in every cycle where a buffered bit exists.
  - cfg_sdo = current LSB; the register shifts right and the pass counter increments.
  - No buffered bit -> cfg_shift_en=0, a stall with no chain activity.
- Partial final word: only the remaining (CHAIN_LEN - bits already taken) low bits are used. The leftover high bits are discarded and bits-left is cleared at pass end.
- A new word is always fetched per pass; a word never spans two passes.
- VERIFY:
  - The host resends the identical bitstream.
  - On each shift of bit k (k=0..CHAIN_LEN-1), config_out sampled in the same cycle must equal cfg_sdo.
  - On the first mismatch: latch err_bit_idx=k and set error. Shifting continues to the end so the stream stays aligned.
  - The chain ends holding the same contents.
- Pass counter: compare with CHAIN_LEN-1 at the strobe. The final shift of a pass and the state transition occur in the same cycle; no extra cycle is spent.
- Latency with no stalls:
  - start -> first shift = RST_CYCLES+1 cycles.
  - done rises the cycle after the final shift.
- DONE: cfg_shift_en=0 and s_ready=0. Extra words are not consumed.

Test Plan:
- CHAIN_LEN=14, WORD_W=8, RST_CYCLES=4, verify_en=0; start, then words 0xA5, 0x3C with s_valid held -> config_reset high 4 cycles; 14 consecutive strobes carrying sdo 1,0,1,0,0,1,0,1,0,0,1,1,1,1 (0x3C bits 6–7 dropped); done 1 cycle later; chain model = bits in order.
- Same stream with verify_en=1 and a 14-bit shift-register chain model, stream resent -> 28 strobes, error=0, done=1.
- As above but chain model bit 5 forced flipped after LOAD -> error=1, err_bit_idx=5, all 28 strobes still issued, done=1.
- s_valid low for 3 cycles mid-word-2 -> exactly 3 strobe-free cycles, no bit lost or duplicated, identical sdo sequence.
- abort asserted on strobe 7 of LOAD -> next cycle IDLE, all outputs 0; a new start reruns RST and the full load cleanly.
- start pulsed again while busy and reset asserted mid-VERIFY -> the second start is ignored; reset forces IDLE with done=0 and error=0.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// Loads a daisy-chained configuration shift chain from a word stream, LSB first,
// with an optional second pass that re-shifts the stream and checks the chain tail.
module cfg_chain_loader #(
   parameter int unsigned CHAIN_LEN  = 256,
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned CNT_W      = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              verify_en,
   input  logic              abort,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              cfg_sdo,
   output logic              cfg_shift_en,
   output logic              config_reset,
   input  logic              config_out,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  err_bit_idx
);

   localparam int unsigned BL_W = $clog2(WORD_W + 1);
   localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_LOAD, S_VERIFY, S_DONE} state_t;

   state_t            state, state_n;
   logic [RC_W-1:0]   rst_cnt;
   logic [WORD_W-1:0] shreg;
   logic [BL_W-1:0]   bits_left;
   logic [CNT_W-1:0]  pass_cnt;
   logic              verify_lat;
   logic              done_r, error_r;
   logic [CNT_W-1:0]  err_idx;

   logic shifting, have_buf, last_bit, accept, shift, sdo_bit, pass_end, mismatch, start_acc;

   always_comb begin
      shifting  = (state == S_LOAD) || (state == S_VERIFY);
      have_buf  = (bits_left != '0);
      last_bit  = (pass_cnt == CNT_W'(CHAIN_LEN - 1));
      // An empty buffer takes the incoming word and shifts its LSB in the same
      // cycle; a word arriving on the last buffered bit refills without a bubble.
      s_ready   = shifting && (!have_buf || (bits_left == BL_W'(1) && !last_bit));
      accept    = s_valid && s_ready;
      shift     = shifting && (have_buf || accept);
      sdo_bit   = have_buf ? shreg[0] : s_data[0];
      pass_end  = shift && last_bit;
      mismatch  = (state == S_VERIFY) && shift && (config_out != sdo_bit);
      start_acc = start && !abort && ((state == S_IDLE) || (state == S_DONE));
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (start) state_n = S_RST;
         S_RST:    if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_n = S_LOAD;
         S_LOAD:   if (pass_end) state_n = verify_lat ? S_VERIFY : S_DONE;
         S_VERIFY: if (pass_end) state_n = S_DONE;
         S_DONE:   if (start) state_n = S_RST;
         default:  state_n = S_IDLE;
      endcase
      if (abort) state_n = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset || abort) begin
         state      <= S_IDLE;
         rst_cnt    <= '0;
         shreg      <= '0;
         bits_left  <= '0;
         pass_cnt   <= '0;
         verify_lat <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         err_idx    <= '0;
      end else begin
         state <= state_n;
         if (start_acc) begin
            verify_lat <= verify_en;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_idx    <= '0;
            rst_cnt    <= '0;
         end
         if (state == S_RST) rst_cnt <= rst_cnt + RC_W'(1);
         if (shift) begin
            if (pass_end) begin
               // Leftover high bits of a partial final word are dropped here.
               bits_left <= '0;
               pass_cnt  <= '0;
            end else begin
               pass_cnt <= pass_cnt + CNT_W'(1);
               if (!have_buf) begin
                  shreg     <= s_data >> 1;
                  bits_left <= BL_W'(WORD_W - 1);
               end else if (accept) begin
                  shreg     <= s_data;
                  bits_left <= BL_W'(WORD_W);
               end else begin
                  shreg     <= shreg >> 1;
                  bits_left <= bits_left - BL_W'(1);
               end
            end
         end
         if (pass_end && ((state == S_VERIFY) || !verify_lat)) done_r <= 1'b1;
         if (mismatch && !error_r) begin
            error_r <= 1'b1;
            err_idx <= pass_cnt;
         end
      end
   end

   assign cfg_sdo      = shift & sdo_bit;
   assign cfg_shift_en = shift;
   assign config_reset = (state == S_RST);
   assign busy         = (state == S_RST) || shifting;
   assign done         = done_r;
   assign error        = error_r;
   assign err_bit_idx  = err_idx;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: drives a word stream into a 14-bit chain
// model and checks every strobe against a bit-queue reference model.
module tb_cfg_chain_loader;

   localparam int CL     = 14;
   localparam int WW     = 8;
   localparam int RC     = 4;
   localparam int CW     = $clog2(CL + 1);
   localparam int FLIP_K = 5;

   logic          clk = 1'b0;
   logic          reset, start, verify_en, abort, s_valid, s_ready;
   logic [WW-1:0] s_data;
   logic          cfg_sdo, cfg_shift_en, config_reset, config_out;
   logic          busy, done, error;
   logic [CW-1:0] err_bit_idx;

   always #5 clk = ~clk;

   cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .RST_CYCLES(RC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .verify_en(verify_en), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .cfg_sdo(cfg_sdo),
      .cfg_shift_en(cfg_shift_en), .config_reset(config_reset), .config_out(config_out),
      .busy(busy), .done(done), .error(error), .err_bit_idx(err_bit_idx)
   );

   // Chain model: shift register clocked by the strobe, optional corruption of bit FLIP_K.
   logic [CL-1:0] chain = '0;
   int            ch_strobes = 0;
   bit            flip_mode = 1'b0;
   always @(posedge clk) begin
      if (config_reset) begin
         chain      <= '0;
         ch_strobes <= 0;
      end else if (cfg_shift_en) begin
         if (flip_mode && ch_strobes == CL - 1)
            chain <= {chain[CL-2:0], cfg_sdo} ^ (CL'(1) << (CL - 1 - FLIP_K));
         else
            chain <= {chain[CL-2:0], cfg_sdo};
         ch_strobes <= ch_strobes + 1;
      end
   end
   assign config_out = chain[CL-1];

   int            tests = 0, fails = 0, cyc = 0;
   logic [WW-1:0] wq[$];
   int            gq[$];
   int            gap_left = 0;
   bit            exp_q[$];
   logic [WW-1:0] pass_words[$];
   int            rst_cnt, strobes, first_cyc, last_cyc, done_cyc, start_cyc;
   logic [CL-1:0] cap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Bits of one pass: words LSB first, truncated to CL bits.
   function automatic logic [CL-1:0] pass_vec();
      logic [CL-1:0] v = '0;
      int n = 0;
      foreach (pass_words[i])
         for (int b = 0; b < WW; b++)
            if (n < CL) begin
               v[n] = pass_words[i][b];
               n++;
            end
      return v;
   endfunction

   function automatic void build_model(input int passes);
      logic [CL-1:0] v = pass_vec();
      for (int p = 0; p < passes; p++)
         for (int k = 0; k < CL; k++) exp_q.push_back(v[k]);
   endfunction

   function automatic int first_mismatch(input bit flip);
      logic [CL-1:0] sent   = pass_vec();
      logic [CL-1:0] loaded = sent;
      if (flip) loaded[FLIP_K] = ~loaded[FLIP_K];
      for (int k = 0; k < CL; k++) if (loaded[k] != sent[k]) return k;
      return -1;
   endfunction

   task automatic tick();
      bit acc, e;
      @(negedge clk);
      cyc++;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done) begin
         chk("done_no_shift", 32'(cfg_shift_en), 32'd0);
         chk("done_no_ready", 32'(s_ready), 32'd0);
      end
      if (start && !busy && !reset && !abort) begin
         start_cyc = cyc; strobes = 0; rst_cnt = 0;
         first_cyc = -1; last_cyc = -1; done_cyc = -1; cap = '0;
         exp_q.delete();
         build_model(verify_en ? 2 : 1);
      end
      if (config_reset) rst_cnt++;
      if (cfg_shift_en) begin
         if (exp_q.size() == 0) chk("extra_strobe", 32'd0, 32'd1);
         else begin
            e = exp_q.pop_front();
            chk("sdo", 32'(cfg_sdo), 32'(e));
         end
         if (strobes < CL) cap[strobes] = cfg_sdo;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
         strobes++;
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc && wq.size() > 0) begin
         void'(wq.pop_front());
         gap_left = (gq.size() > 0) ? gq.pop_front() : 0;
      end
      if (gap_left > 0) begin
         s_valid = 1'b0;
         gap_left--;
      end else begin
         s_valid = (wq.size() > 0);
         s_data  = (wq.size() > 0) ? wq[0] : '0;
      end
   endtask

   task automatic run_start(input bit ver, input bit flip, input int gap2);
      pass_words = {8'hA5, 8'h3C};
      flip_mode  = flip;
      wq.delete(); gq.delete();
      for (int p = 0; p < (ver ? 2 : 1); p++) begin
         wq.push_back(8'hA5);
         wq.push_back(8'h3C);
      end
      wq.push_back(8'hFF);
      gq.push_back(gap2);
      for (int i = 0; i < 4; i++) gq.push_back(0);
      gap_left  = 0;
      s_valid   = 1'b1;
      s_data    = wq[0];
      verify_en = ver;
      start     = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && done_cyc < 0; i++) tick();
      if (done_cyc < 0) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic check_run(input bit ver, input bit flip, input int exp_stall);
      logic [CL-1:0] rev;
      int k;
      for (int i = 0; i < CL; i++) rev[i] = chain[CL-1-i];
      chk("rst_cycles", 32'(rst_cnt), 32'(RC));
      chk("start_to_first_shift", 32'(first_cyc - start_cyc), 32'(RC + 1));
      chk("strobe_count", 32'(strobes), ver ? 32'(2 * CL) : 32'(CL));
      chk("stall_cycles", 32'((last_cyc - first_cyc + 1) - strobes), 32'(exp_stall));
      chk("done_latency", 32'(done_cyc - last_cyc), 32'd1);
      chk("load_sdo_literal", 32'(cap), 32'h3CA5);
      chk("model_drained", 32'(exp_q.size()), 32'd0);
      chk("chain_contents", 32'(rev), 32'(pass_vec()));
      k = first_mismatch(flip && ver);
      chk("error_flag", 32'(error), (k >= 0) ? 32'd1 : 32'd0);
      chk("err_bit_idx", 32'(err_bit_idx), (k >= 0) ? 32'(k) : 32'd0);
      if (flip && ver) chk("err_bit_idx_literal", 32'(err_bit_idx), 32'd5);
      repeat (4) tick();
      chk("extra_word_pending", 32'(wq.size()), 32'd1);
      chk("done_sticky", 32'(done), 32'd1);
      wq.delete(); gq.delete(); gap_left = 0;
      tick();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_err_idx"}, 32'(err_bit_idx), 32'd0);
      chk({tag, "_outs"}, {28'd0, s_ready, cfg_sdo, cfg_shift_en, config_reset}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
      s_valid = 1'b0; s_data = '0;
      rst_cnt = 0; strobes = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; start_cyc = 0; cap = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk_idle("reset");

      run_start(1'b0, 1'b0, 0);  wait_done(); check_run(1'b0, 1'b0, 0);
      run_start(1'b1, 1'b0, 0);  wait_done(); check_run(1'b1, 1'b0, 0);
      run_start(1'b1, 1'b1, 0);  wait_done(); check_run(1'b1, 1'b1, 0);
      run_start(1'b0, 1'b0, 10); wait_done(); check_run(1'b0, 1'b0, 3);

      // Abort on the 7th strobe of LOAD, then a clean rerun.
      run_start(1'b0, 1'b0, 0);
      for (int i = 0; i < 100 && strobes < 6; i++) tick();
      chk("pre_abort_strobes", 32'(strobes), 32'd6);
      abort = 1'b1;
      tick();
      chk_idle("abort");
      abort = 1'b0;
      wq.delete(); gq.delete(); exp_q.delete(); gap_left = 0;
      tick();
      run_start(1'b0, 1'b0, 0); wait_done(); check_run(1'b0, 1'b0, 0);

      // Start while busy is ignored; reset mid-VERIFY clears everything.
      run_start(1'b1, 1'b1, 0);
      for (int i = 0; i < 100 && strobes < 3; i++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && strobes < CL + 10; i++) tick();
      chk("mid_verify_strobes", 32'(strobes), 32'(CL + 10));
      chk("no_second_reset", 32'(rst_cnt), 32'(RC));
      chk("mid_verify_error", 32'(error), 32'd1);
      reset = 1'b1;
      tick();
      chk_idle("reset_mid_verify");
      reset = 1'b0;
      wq.delete(); gq.delete(); exp_q.delete(); gap_left = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
